// File: rtl/free_list_pkg.sv
// Shared configuration for the physical-register free list: register counts,
// list depth and pointer width (index bits plus one wrap bit).
package free_list_pkg;

    localparam int NUM_PHYS        = 64;
    localparam int NUM_ARCH        = 32;
    localparam int PROJ_LOG_PHYS   = $clog2(NUM_PHYS);
    localparam int FREE_LIST_DEPTH = NUM_PHYS - NUM_ARCH;

    // Pointer = index into a power-of-two ring plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(FREE_LIST_DEPTH);

endpackage

// File: rtl/free_list.sv
// Rename free list: circular FIFO of free physical registers with speculative
// and committed heads. Optional same-cycle bypass when FREE_LIST_BYPASS_EN is defined.
module free_list
    import free_list_pkg::*;
#(
    parameter int NUM_PHYS = free_list_pkg::NUM_PHYS,
    parameter int NUM_ARCH = free_list_pkg::NUM_ARCH
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  Grabbed_regs,
    input  logic                                  Retire_valid,
    input  logic [$clog2(NUM_PHYS)-1:0]           Retire_old_phys_reg,
    input  logic                                  Recover,
    output logic [$clog2(NUM_PHYS)-1:0]           Free_phys_reg,
    output logic                                  Free_reg_avail,
    output logic [$clog2(NUM_PHYS-NUM_ARCH):0]    Free_count,
    output logic                                  Error
);

    localparam int DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = ptr_w(DEPTH);
    localparam int RW    = $clog2(NUM_PHYS);

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] tail;
    logic [PW-1:0] spec_head;
    logic [PW-1:0] arch_head;

    logic          list_avail;
    logic [RW-1:0] head_reg;
    logic          grab_ok;
    logic          grab_bad;
    logic          retire_bad;
    logic          reg_zero;
    logic          arch_adv;
    logic          do_push;
    logic [PW-1:0] arch_next;

    assign list_avail = (tail != spec_head);
    assign head_reg   = mem[spec_head[IDX_W-1:0]];
    assign reg_zero   = (Retire_old_phys_reg == '0);
    assign Free_count = tail - spec_head;

`ifdef FREE_LIST_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit     = !list_avail && Retire_valid && !reg_zero;
    assign Free_reg_avail = list_avail || bypass_hit;
    assign Free_phys_reg  = bypass_hit ? Retire_old_phys_reg : head_reg;
`else
    assign Free_reg_avail = list_avail;
    assign Free_phys_reg  = head_reg;
`endif

    always_comb begin
        grab_ok    = Grabbed_regs && Free_reg_avail && !Recover;
        grab_bad   = Grabbed_regs && !Free_reg_avail && !Recover;
        // A retire with no outstanding allocation (arch_head caught up with
        // spec_head and no grab this cycle) would push the list past full.
        retire_bad = Retire_valid && (arch_head == spec_head) && !grab_ok;
        arch_adv   = Retire_valid && !retire_bad;
        do_push    = arch_adv && !reg_zero;
        arch_next  = arch_head + PW'(arch_adv);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RW'(NUM_ARCH + i);
            end
            tail      <= PW'(DEPTH);
            spec_head <= '0;
            arch_head <= '0;
            Error     <= 1'b0;
        end else begin
            // The slot is written even when a bypass grab consumes the value,
            // so a later recovery still sees the correct register number.
            if (do_push) begin
                mem[tail[IDX_W-1:0]] <= Retire_old_phys_reg;
            end
            tail      <= tail + PW'(do_push);
            arch_head <= arch_next;
            spec_head <= Recover ? arch_next : spec_head + PW'(grab_ok);
            if (grab_bad || retire_bad || (Retire_valid && reg_zero)) begin
                Error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with a queue model of the list contents
// (committed head at the front) and a speculative offset into it.
module tb_free_list;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       Grabbed_regs;
    logic       Retire_valid;
    logic [5:0] Retire_old_phys_reg;
    logic       Recover;
    logic [5:0] Free_phys_reg;
    logic       Free_reg_avail;
    logic [5:0] Free_count;
    logic       Error;

    free_list dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .Grabbed_regs        (Grabbed_regs),
        .Retire_valid        (Retire_valid),
        .Retire_old_phys_reg (Retire_old_phys_reg),
        .Recover             (Recover),
        .Free_phys_reg       (Free_phys_reg),
        .Free_reg_avail      (Free_reg_avail),
        .Free_count          (Free_count),
        .Error               (Error)
    );

    always #5 CLK = ~CLK;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [5:0] exp_q[$];
    int         spec_off;
    logic       exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
        spec_off = 0;
        exp_err  = 1'b0;
    endtask

    // Optionally holds grab/retire asserted while reset is low: nothing may apply.
    task automatic do_reset(input logic busy);
        Grabbed_regs        = busy;
        Retire_valid        = busy;
        Retire_old_phys_reg = busy ? 6'd7 : 6'd0;
        Recover             = 1'b0;
        RESET               = 1'b0;
        #1;
        model_reset();
        chk("rst_phys",  Free_phys_reg,  exp_q[0]);
        chk("rst_avail", Free_reg_avail, 1'b1);
        chk("rst_count", Free_count,     exp_q.size());
        chk("rst_err",   Error,          exp_err);
        @(posedge CLK);
        #1;
        chk("rst_hold_phys",  Free_phys_reg, exp_q[0]);
        chk("rst_hold_count", Free_count,    exp_q.size());
        Grabbed_regs        = 1'b0;
        Retire_valid        = 1'b0;
        Retire_old_phys_reg = 6'd0;
        RESET               = 1'b1;
    endtask

    task automatic cycle(input logic g, input logic rv, input logic [5:0] r,
                         input logic rc, input string tag);
        logic       avail_m;
        logic [5:0] phys_m;
        logic       grab_ok;
        int         cnt;
        Grabbed_regs        = g;
        Retire_valid        = rv;
        Retire_old_phys_reg = r;
        Recover             = rc;
        #1;
        avail_m = (spec_off < exp_q.size());
        phys_m  = avail_m ? exp_q[spec_off] : 6'd0;
`ifdef FREE_LIST_BYPASS_EN
        if (!avail_m && rv && r != 6'd0) begin
            avail_m = 1'b1;
            phys_m  = r;
        end
`endif
        cnt = exp_q.size() - spec_off;
        chk({tag, ":avail"}, Free_reg_avail, avail_m);
        if (avail_m) chk({tag, ":phys"}, Free_phys_reg, phys_m);
        chk({tag, ":count"}, Free_count, cnt);

        grab_ok = g && !rc && avail_m;
        if (g && !rc && !avail_m) exp_err = 1'b1;
        if (grab_ok) spec_off++;
        if (rv) begin
            if (spec_off == 0) begin
                exp_err = 1'b1;
            end else begin
                void'(exp_q.pop_front());
                spec_off--;
                if (r == 6'd0) exp_err = 1'b1;
                else exp_q.push_back(r);
            end
        end
        if (rc) spec_off = 0;

        @(posedge CLK);
        #1;
        chk({tag, ":err"}, Error, exp_err);
    endtask

    initial begin
        RESET               = 1'b0;
        Grabbed_regs        = 1'b0;
        Retire_valid        = 1'b0;
        Retire_old_phys_reg = 6'd0;
        Recover             = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset(1'b0);

        // drain the whole list, then underflow
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 6'd0, 1'b0, "grab_all");
        cycle(1'b0, 1'b0, 6'd0, 1'b0, "empty");
        cycle(1'b1, 1'b0, 6'd0, 1'b0, "grab_empty");
        cycle(1'b0, 1'b0, 6'd0, 1'b0, "err_sticky");
        do_reset(1'b1);

        // speculative grabs, two commits, flush
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 6'd0, 1'b0, "grab3");
        cycle(1'b0, 1'b1, 6'd5, 1'b0, "ret5");
        cycle(1'b0, 1'b1, 6'd9, 1'b0, "ret9");
        cycle(1'b1, 1'b0, 6'd0, 1'b1, "recover");
        cycle(1'b0, 1'b0, 6'd0, 1'b0, "post_rec");
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 6'd0, 1'b0, "grab30");
        cycle(1'b1, 1'b0, 6'd0, 1'b0, "grab5");
        cycle(1'b1, 1'b0, 6'd0, 1'b0, "grab9");
        do_reset(1'b0);

        // retire into an empty list
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 6'd0, 1'b0, "drain");
        cycle(1'b0, 1'b1, 6'd17, 1'b0, "ret17_empty");
        cycle(1'b0, 1'b0, 6'd0, 1'b0, "see17");
        cycle(1'b1, 1'b0, 6'd0, 1'b0, "grab17");
`ifdef FREE_LIST_BYPASS_EN
        cycle(1'b1, 1'b1, 6'd21, 1'b0, "byp_grab21");
        cycle(1'b0, 1'b0, 6'd0, 1'b0, "byp_after");
`endif
        do_reset(1'b0);

        // steady state: allocate and free every cycle, pointers wrap
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 6'd12, 1'b0, "steady");
        cycle(1'b0, 1'b0, 6'd0, 1'b1, "steady_rec");
        cycle(1'b0, 1'b0, 6'd0, 1'b0, "steady_idle");

        // retire of register 0
        cycle(1'b1, 1'b0, 6'd0, 1'b0, "pre_ret0");
        cycle(1'b0, 1'b1, 6'd0, 1'b0, "ret0");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'd0, 1'b0, "ret0_sticky");
        do_reset(1'b0);

        // retire with nothing allocated: dropped
        cycle(1'b0, 1'b1, 6'd20, 1'b0, "ret_full");
        cycle(1'b0, 1'b0, 6'd0, 1'b0, "ret_full_after");
        do_reset(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        tests_failed++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

endmodule
